// File: rtl/capt_rd_sched.sv
// Capture FIFO read scheduler: clears the checksum, aligns to start-of-frame, then
// drains bytes to the host in host-paced bursts of burst_len bytes.
module capt_rd_sched #(
    parameter int CLR_CYCLES = 4,
    parameter int LEN_W      = 16,
    parameter int TMO_CYCLES = 65535
) (
    input  logic             clk_reg,
    input  logic             rst_reg_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             host_rdy,
    input  logic             cfifo_rd_vld,
    input  logic [7:0]       cfifo_rd_data,
    input  logic             sob,
    input  logic             eob,
    input  logic             capt_fifo_underrun,
    output logic             cfifo_rd_en,
    output logic             clr_chksm,
    output logic             resume_fill,
    output logic             host_vld,
    output logic [7:0]       host_data,
    output logic             busy,
    output logic             burst_done,
    output logic             frame_done,
    output logic [31:0]      frm_byte_cnt,
    output logic [1:0]       err_code
);
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_UNDERRUN = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic [2:0] {IDLE, CLR, WAIT_SOB, BURST, PAUSE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bcnt;
    logic [LEN_W-1:0] last_idx;
    logic [CLR_W-1:0] clr_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             abort_hit, unrun_hit, kill;
    logic             discard, xfer, pop;
    logic             tmo_hit, burst_end, enter_burst;

    // Abort and underrun suppress any pop in the cycle they are seen.
    assign abort_hit   = abort && (state != IDLE);
    assign unrun_hit   = capt_fifo_underrun && (state != IDLE) && (state != CLR);
    assign kill        = abort_hit || unrun_hit;
    assign discard     = (state == WAIT_SOB) && cfifo_rd_vld && !sob && !kill;
    assign xfer        = (state == BURST) && cfifo_rd_vld && host_rdy && !kill;
    assign pop         = discard || xfer;
    assign tmo_hit     = ((state == WAIT_SOB) || (state == BURST)) && !pop &&
                         (tmo_cnt == TMO_W'(TMO_CYCLES - 1));
    assign last_idx    = (len_q == '0) ? '0 : len_q - LEN_W'(1);
    assign burst_end   = xfer && (bcnt == last_idx);
    assign enter_burst = (state_nxt == BURST) && (state != BURST);

    always_ff @(posedge clk_reg or negedge rst_reg_n) begin
        if (!rst_reg_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = CLR;
            CLR:      if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = WAIT_SOB;
            WAIT_SOB: begin
                if (tmo_hit)                  state_nxt = IDLE;
                else if (cfifo_rd_vld && sob) state_nxt = BURST;
            end
            BURST: begin
                if (tmo_hit)          state_nxt = IDLE;
                else if (xfer && eob) state_nxt = IDLE;
                else if (burst_end)   state_nxt = PAUSE;
            end
            PAUSE:    if (cont) state_nxt = BURST;
            default:  state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_comb begin
        cfifo_rd_en = pop;
        host_vld    = (state == BURST) && cfifo_rd_vld && !kill;
        host_data   = cfifo_rd_data;
        clr_chksm   = (state == CLR) && !abort;
        busy        = (state != IDLE);
    end

    always_ff @(posedge clk_reg or negedge rst_reg_n) begin
        if (!rst_reg_n) begin
            len_q        <= '0;
            bcnt         <= '0;
            clr_cnt      <= '0;
            tmo_cnt      <= '0;
            frm_byte_cnt <= '0;
            err_code     <= ERR_NONE;
            burst_done   <= 1'b0;
            frame_done   <= 1'b0;
            resume_fill  <= 1'b0;
        end else begin
            clr_cnt <= (state == CLR) ? clr_cnt + CLR_W'(1) : '0;

            // Idle timer only runs while the scheduler expects data to move.
            if (((state == WAIT_SOB) || (state == BURST)) && !pop)
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else
                tmo_cnt <= '0;

            if (state == IDLE && start) begin
                len_q        <= burst_len;
                frm_byte_cnt <= '0;
                err_code     <= ERR_NONE;
            end else if (xfer) begin
                frm_byte_cnt <= frm_byte_cnt + 32'd1;
            end

            if (enter_burst)
                bcnt <= '0;
            else if (xfer)
                bcnt <= bcnt + LEN_W'(1);

            if (abort_hit)
                err_code <= ERR_ABORT;
            else if (unrun_hit)
                err_code <= ERR_UNDERRUN;
            else if (tmo_hit)
                err_code <= ERR_TIMEOUT;

            burst_done  <= burst_end && !eob;
            frame_done  <= xfer && eob;
            resume_fill <= enter_burst;
        end
    end
endmodule
